// File: rtl/pi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pi_pkg
// Description : Shared widths and FSM state encoding for the incremental
//               PI controller (pi) and its saturation stage (pi_sat).
// Contents    : DW - operand width, RW - result width, SW - sum width,
//               PW/IW - P and I product widths, state_t - FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package pi_pkg;

   localparam int DW = 32;          // operand width
   localparam int RW = 64;          // result width
   localparam int SW = 66;          // full-precision sum width
   localparam int PW = 2*DW + 1;    // kp * (33-bit difference)
   localparam int IW = 2*DW;        // ki * ek

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DIFF = 3'd1,
      S_MULT = 3'd2,
      S_SUM  = 3'd3,
      S_SAT  = 3'd4
   } state_t;

endpackage : pi_pkg
`default_nettype wire

// File: rtl/pi_sat.sv
`default_nettype none
// ============================================================================
// Module      : pi_sat
// Description : Combinational clamp of the 66-bit PI sum into
//               [sext(uk_min), sext(uk_max)]. The upper limit is applied
//               first, then the lower one, so inverted limits yield uk_min.
// Ports       : sum    [65:0] in  - full-precision signed sum
//               uk_min [31:0] in  - lower limit, signed
//               uk_max [31:0] in  - upper limit, signed
//               sat    [63:0] out - clamped, sign-extended value
// Revision    : 1.0 - initial release
// ============================================================================
module pi_sat
   import pi_pkg::*;
(
   input  logic [SW-1:0] sum,
   input  logic [DW-1:0] uk_min,
   input  logic [DW-1:0] uk_max,
   output logic [RW-1:0] sat
);

   logic [SW-1:0] w_max_sw;
   logic [SW-1:0] w_min_sw;
   logic          w_gt_max;
   logic          w_lt_min;

   assign w_max_sw = {{(SW-DW){uk_max[DW-1]}}, uk_max};
   assign w_min_sw = {{(SW-DW){uk_min[DW-1]}}, uk_min};

   // The lower-limit test must look at the value left after the upper clamp:
   // either uk_max itself or the raw sum. All compares are done before any
   // truncation so a large sum can never wrap into range.
   always_comb begin
      w_gt_max = ($signed(sum) > $signed(w_max_sw));
      if (w_gt_max) begin
         w_lt_min = ($signed(uk_max) < $signed(uk_min));
      end else begin
         w_lt_min = ($signed(sum) < $signed(w_min_sw));
      end

      if (w_lt_min) begin
         sat = {{(RW-DW){uk_min[DW-1]}}, uk_min};
      end else if (w_gt_max) begin
         sat = {{(RW-DW){uk_max[DW-1]}}, uk_max};
      end else begin
         sat = sum[RW-1:0];
      end
   end

endmodule : pi_sat
`default_nettype wire

// File: rtl/pi.sv
`default_nettype none
// ============================================================================
// Module      : pi
// Description : Incremental PI controller
//                  u(k) = uk_ex + kp*(ek - ek_ex) + ki*ek
//               computed over a fixed IDLE->DIFF->MULT->SUM->SAT sequence.
//               Result is valid (done pulse) 4 edges after the start edge.
// Ports       : clk             in  - clock, rising edge
//               rst_n           in  - asynchronous active-low reset
//               pista           in  - start pulse, sampled in IDLE only
//               uk_ex,kp,ek,ek_ex,ki,uk_min,uk_max [31:0] in - signed data
//               result   [63:0] out - clamped u(k), held until next done
//               done            out - one-cycle completion pulse
//               busy            out - high while an operation is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module pi
   import pi_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pista,
   input  logic [DW-1:0] uk_ex,
   input  logic [DW-1:0] kp,
   input  logic [DW-1:0] ek,
   input  logic [DW-1:0] ek_ex,
   input  logic [DW-1:0] ki,
   input  logic [DW-1:0] uk_min,
   input  logic [DW-1:0] uk_max,
   output logic [RW-1:0] result,
   output logic          done,
   output logic          busy
);

   state_t        state_q, state_d;

   logic [DW-1:0] uk_ex_q, kp_q, ek_q, ek_ex_q, ki_q, uk_min_q, uk_max_q;
   logic [DW:0]   diff_q;
   logic [PW-1:0] prod_p_q;
   logic [IW-1:0] prod_i_q;
   logic [SW-1:0] sum_q;
   logic [RW-1:0] result_q;
   logic          done_q;

   logic          w_start;
   logic [DW:0]   w_diff;
   logic [PW-1:0] w_prod_p;
   logic [IW-1:0] w_prod_i;
   logic [SW-1:0] w_sum;
   logic [RW-1:0] w_sat;

   // Start is only honoured in IDLE; in the done cycle the FSM is already
   // back in IDLE, which gives back-to-back operation for free.
   assign w_start = (state_q == S_IDLE) && pista;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (pista) state_d = S_DIFF;
         S_DIFF:  state_d = S_MULT;
         S_MULT:  state_d = S_SUM;
         S_SUM:   state_d = S_SAT;
         S_SAT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: every operand is sign-extended to the full product/sum width
   // so the arithmetic is exact and nothing overflows before the clamp.
   assign w_diff   = {ek_q[DW-1], ek_q} - {ek_ex_q[DW-1], ek_ex_q};
   assign w_prod_p = $signed({{(PW-DW-1){diff_q[DW]}}, diff_q})
                   * $signed({{(PW-DW){kp_q[DW-1]}}, kp_q});
   assign w_prod_i = $signed({{(IW-DW){ki_q[DW-1]}}, ki_q})
                   * $signed({{(IW-DW){ek_q[DW-1]}}, ek_q});
   assign w_sum    = {{(SW-DW){uk_ex_q[DW-1]}}, uk_ex_q}
                   + {{(SW-PW){prod_p_q[PW-1]}}, prod_p_q}
                   + {{(SW-IW){prod_i_q[IW-1]}}, prod_i_q};

   pi_sat u_sat (
      .sum    (sum_q),
      .uk_min (uk_min_q),
      .uk_max (uk_max_q),
      .sat    (w_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         uk_ex_q  <= '0;
         kp_q     <= '0;
         ek_q     <= '0;
         ek_ex_q  <= '0;
         ki_q     <= '0;
         uk_min_q <= '0;
         uk_max_q <= '0;
         diff_q   <= '0;
         prod_p_q <= '0;
         prod_i_q <= '0;
         sum_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == S_SAT);
         if (w_start) begin
            uk_ex_q  <= uk_ex;
            kp_q     <= kp;
            ek_q     <= ek;
            ek_ex_q  <= ek_ex;
            ki_q     <= ki;
            uk_min_q <= uk_min;
            uk_max_q <= uk_max;
         end
         if (state_q == S_DIFF) diff_q <= w_diff;
         if (state_q == S_MULT) begin
            prod_p_q <= w_prod_p;
            prod_i_q <= w_prod_i;
         end
         if (state_q == S_SUM) sum_q    <= w_sum;
         if (state_q == S_SAT) result_q <= w_sat;
      end
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = (state_q != S_IDLE);

endmodule : pi
`default_nettype wire

// File: tb/tb_pi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pi
// Description : Directed self-checking bench for the pi controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pi;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pista = 1'b0;
   logic [31:0] uk_ex = '0, kp = '0, ek = '0, ek_ex = '0, ki = '0;
   logic [31:0] uk_min = '0, uk_max = '0;
   logic [63:0] result;
   logic        done;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   pi dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .pista  (pista),
      .uk_ex  (uk_ex),
      .kp     (kp),
      .ek     (ek),
      .ek_ex  (ek_ex),
      .ki     (ki),
      .uk_min (uk_min),
      .uk_max (uk_max),
      .result (result),
      .done   (done),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic set_inputs(input logic [31:0] a_uk_ex, a_kp, a_ek, a_ek_ex,
                             a_ki, a_min, a_max);
      uk_ex = a_uk_ex; kp = a_kp; ek = a_ek; ek_ex = a_ek_ex;
      ki = a_ki; uk_min = a_min; uk_max = a_max;
   endtask

   task automatic scramble_inputs();
      set_inputs($urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom);
   endtask

   // Issues one start, scrambles the inputs right after the accepting edge
   // and reports the done latency (edges after the accept, -1 on timeout),
   // the result, and busy as seen just after the accepting edge.
   task automatic run_op(input logic [31:0] a_uk_ex, a_kp, a_ek, a_ek_ex,
                         a_ki, a_min, a_max,
                         output int lat, output logic [63:0] res,
                         output logic busy1);
      @(negedge clk);
      set_inputs(a_uk_ex, a_kp, a_ek, a_ek_ex, a_ki, a_min, a_max);
      pista = 1'b1;
      @(posedge clk); #1;
      pista = 1'b0;
      busy1 = busy;
      scramble_inputs();
      lat = -1;
      res = '0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            res = result;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pista = i[0];
         set_inputs(32'h46, 32'h2, 32'h66, 32'h12, 32'h36, 32'h0, 32'h7FFFFFFF);
         @(posedge clk); #1;
         n_checks++;
         if (result !== 64'h0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: result=%h done=%b busy=%b required result=0 done=0 busy=0",
                     result, done, busy);
         end
      end
      @(negedge clk);
      pista = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic test_inverted_limits();
      int lat; logic [63:0] res; logic b1;
      run_op(32'h46, 32'hFFFFFFFF, 32'h66, 32'h12, 32'h36, 32'h32569,
             32'hFFFFFFFF, lat, res, b1);
      n_checks++;
      if (lat !== 4) begin
         n_fail++;
         $display("FAIL inverted_latency: got %0d required 4", lat);
      end
      n_checks++;
      if (res !== 64'h0000_0000_0003_2569) begin
         n_fail++;
         $display("FAIL inverted_result: got %h required 0000000000032569", res);
      end
      n_checks++;
      if (b1 !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_after_start: got %b required 1", b1);
      end
   endtask

   task automatic test_nominal();
      int lat; logic [63:0] res; logic b1;
      run_op(32'h46, 32'h2, 32'h66, 32'h12, 32'h36, 32'h0, 32'h7FFFFFFF,
             lat, res, b1);
      n_checks++;
      if (lat !== 4 || res !== 64'h1672) begin
         n_fail++;
         $display("FAIL nominal: lat=%0d result=%h required lat=4 result=1672", lat, res);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_at_done: got %b required 0", busy);
      end
      // result must hold and done must fall after the completion
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (result !== 64'h1672 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: result=%h done=%b required 1672 0", result, done);
         end
      end
   endtask

   task automatic test_upper_clamp();
      int lat; logic [63:0] res; logic b1;
      run_op(32'h46, 32'h2, 32'h66, 32'h12, 32'h36, 32'h0, 32'h1000,
             lat, res, b1);
      n_checks++;
      if (lat !== 4 || res !== 64'h1000) begin
         n_fail++;
         $display("FAIL upper_clamp: lat=%0d result=%h required lat=4 result=1000", lat, res);
      end
   endtask

   task automatic test_lower_clamp();
      int lat; logic [63:0] res; logic b1;
      run_op(32'h0, 32'h1, 32'hFFFFFFF6, 32'h0, 32'h1, 32'hFFFFFFF0, 32'd100,
             lat, res, b1);
      n_checks++;
      if (lat !== 4 || res !== 64'hFFFF_FFFF_FFFF_FFF0) begin
         n_fail++;
         $display("FAIL lower_clamp: lat=%0d result=%h required lat=4 result=fffffffffffffff0", lat, res);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic [63:0] res; logic b1;
      int lat2; logic [63:0] res2;
      run_op(32'h46, 32'h2, 32'h66, 32'h12, 32'h36, 32'h0, 32'h7FFFFFFF,
             lat, res, b1);
      // now in the done cycle: start the next operation immediately
      set_inputs(32'h0, 32'h1, 32'hFFFFFFF6, 32'h0, 32'h1, 32'hFFFFFFF0, 32'd100);
      pista = 1'b1;
      @(posedge clk); #1;
      pista = 1'b0;
      scramble_inputs();
      lat2 = -1;
      res2 = '0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat2 = i;
            res2 = result;
            break;
         end
      end
      n_checks++;
      if (lat !== 4 || res !== 64'h1672) begin
         n_fail++;
         $display("FAIL b2b_first: lat=%0d result=%h required lat=4 result=1672", lat, res);
      end
      n_checks++;
      if (lat2 !== 4 || res2 !== 64'hFFFF_FFFF_FFFF_FFF0) begin
         n_fail++;
         $display("FAIL b2b_second: lat=%0d result=%h required lat=4 result=fffffffffffffff0", lat2, res2);
      end
   endtask

   task automatic test_busy_ignore();
      int n_done = 0;
      int first = -1;
      logic [63:0] res = '0;
      @(negedge clk);
      set_inputs(32'h46, 32'h2, 32'h66, 32'h12, 32'h36, 32'h0, 32'h7FFFFFFF);
      pista = 1'b1;
      @(posedge clk); #1;
      pista = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         // second start request held across edges 2 and 3 while busy
         if (i == 1) begin
            set_inputs(32'h46, 32'h2, 32'h66, 32'h12, 32'h36, 32'h0, 32'h1000);
            pista = 1'b1;
         end
         if (i == 3) pista = 1'b0;
         if (done) begin
            n_done++;
            if (first < 0) begin
               first = i;
               res = result;
            end
         end
      end
      n_checks++;
      if (n_done !== 1 || first !== 4 || res !== 64'h1672) begin
         n_fail++;
         $display("FAIL busy_ignore: dones=%0d at=%0d result=%h required 1 dones at 4 result=1672",
                  n_done, first, res);
      end
   endtask

   task automatic test_reset_abort();
      int n_done = 0;
      @(negedge clk);
      set_inputs(32'h46, 32'h2, 32'h66, 32'h12, 32'h36, 32'h0, 32'h7FFFFFFF);
      pista = 1'b1;
      @(posedge clk); #1;
      pista = 1'b0;
      @(posedge clk); #1;   // FSM now in MULT
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (result !== 64'h0 || done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_async: result=%h done=%b busy=%b required 0 0 0", result, done, busy);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      n_checks++;
      if (n_done !== 0 || result !== 64'h0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: dones=%0d result=%h busy=%b required 0 0 0", n_done, result, busy);
      end
   endtask

   initial begin
      test_reset();
      test_inverted_limits();
      test_nominal();
      test_upper_clamp();
      test_lower_clamp();
      test_back_to_back();
      test_busy_ignore();
      test_reset_abort();
      test_nominal();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_pi
`default_nettype wire
